// File: rtl/adc_if_pkg.sv
// Shared types for the receive-side 2-to-5 sample gearbox and word aligner.
//   sample_t      : one ADC sample
//   beat_t        : 2-sample deserializer beat, [0] older
//   word_t        : 5-sample output word, [0] oldest
//   align_state_t : aligner FSM states
//   is_train_word : true when a word is the training ramp base..base+4
package adc_if_pkg;

    localparam int W = 14;

    typedef logic [W-1:0] sample_t;
    typedef sample_t [1:0] beat_t;
    typedef sample_t [4:0] word_t;

    localparam sample_t TRAIN_BASE_DEF = 14'h0100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HUNT,
        ST_WAIT,
        ST_CHECK,
        ST_LOCKED
    } align_state_t;

    // Ramp arithmetic wraps at 2^W.
    function automatic logic is_train_word(word_t w, sample_t base);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (w[k] != sample_t'(base + sample_t'(k))) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/adc_gearbox_2to5.sv
// 2-to-5 sample gearbox with single-sample slip.
//   clk320     : sample-word clock
//   reset_n    : async active-low reset
//   din_valid  : din holds a new beat
//   din        : 2-sample beat, [0] older
//   slip_req   : drop din[0] of the next valid beat after this cycle
//   dout_valid : one-cycle pulse, dout holds a new word
//   dout       : 5-sample word, [0] oldest
module adc_gearbox_2to5
    import adc_if_pkg::*;
(
    input  logic  clk320,
    input  logic  reset_n,
    input  logic  din_valid,
    input  beat_t din,
    input  logic  slip_req,
    output logic  dout_valid,
    output word_t dout
);

    sample_t [5:0] smp_q, smp_n;
    logic [2:0]    occ_q, occ_n;
    logic          slip_pend_q, slip_pend_n;
    logic          emit;
    word_t         word_n;

    always_comb begin
        smp_n       = smp_q;
        occ_n       = occ_q;
        emit        = 1'b0;
        word_n      = '0;
        slip_pend_n = slip_pend_q;

        // A request arriving while one is pending is dropped; a request in
        // the same cycle as a beat only affects later beats.
        if (!slip_pend_q) begin
            slip_pend_n = slip_req;
        end else if (din_valid) begin
            slip_pend_n = 1'b0;
        end

        if (din_valid) begin
            if (!slip_pend_q) begin
                smp_n[occ_n] = din[0];
                occ_n        = occ_n + 3'd1;
            end
            smp_n[occ_n] = din[1];
            occ_n        = occ_n + 3'd1;

            // Occupancy is at most 4 before a beat, so at most one word per beat.
            if (occ_n >= 3'd5) begin
                emit      = 1'b1;
                word_n    = smp_n[4:0];
                smp_n[0]  = smp_n[5];
                smp_n[5:1] = '0;
                occ_n     = occ_n - 3'd5;
            end
        end
    end

    always_ff @(posedge clk320 or negedge reset_n) begin
        if (!reset_n) begin
            smp_q       <= '0;
            occ_q       <= '0;
            slip_pend_q <= 1'b0;
            dout_valid  <= 1'b0;
            dout        <= '0;
        end else begin
            smp_q       <= smp_n;
            occ_q       <= occ_n;
            slip_pend_q <= slip_pend_n;
            dout_valid  <= emit;
            if (emit) dout <= word_n;
        end
    end

endmodule

// File: rtl/adc_if_2to5.sv
// Receive-side 2-to-5 gearbox with training-ramp word aligner.
//   clk320     : sample-word clock (320 MHz)
//   reset_n    : async active-low reset
//   din_valid  : din carries a new beat
//   din        : 2-sample beat, [0] older
//   align_en   : link is sending the training ramp
//   dout_valid : one-cycle pulse per new word
//   dout       : 5-sample word, [0] oldest
//   locked     : word alignment achieved
//   align_err  : sticky, MAX_SLIPS slips without lock
//   slip_cnt   : slips since last HUNT entry, saturating at 15
//
// state  | meaning
// IDLE   | aligner off, not locked
// HUNT   | judge next word; good -> CHECK, bad -> slip
// WAIT   | let SETTLE words pass after a slip
// CHECK  | counting consecutive good words toward lock
// LOCKED | aligned; a bad word re-hunts only while align_en
module adc_if_2to5
    import adc_if_pkg::*;
#(
    parameter sample_t TRAIN_BASE  = TRAIN_BASE_DEF,
    parameter int      MATCH_COUNT = 16,
    parameter int      SETTLE      = 4,
    parameter int      MAX_SLIPS   = 10
) (
    input  logic       clk320,
    input  logic       reset_n,
    input  logic       din_valid,
    input  beat_t      din,
    input  logic       align_en,
    output logic       dout_valid,
    output word_t      dout,
    output logic       locked,
    output logic       align_err,
    output logic [3:0] slip_cnt
);

    localparam int MW = $clog2(MATCH_COUNT + 1);
    localparam int SW = $clog2(SETTLE + 1);

    align_state_t  state_q, state_n;
    logic [MW-1:0] match_q, match_n;
    logic [SW-1:0] settle_q, settle_n;
    logic [3:0]    slips_n;
    logic          err_n;
    logic          slip_req;
    logic          good;

    adc_gearbox_2to5 u_gearbox (
        .clk320     (clk320),
        .reset_n    (reset_n),
        .din_valid  (din_valid),
        .din        (din),
        .slip_req   (slip_req),
        .dout_valid (dout_valid),
        .dout       (dout)
    );

    assign good   = is_train_word(dout, TRAIN_BASE);
    assign locked = (state_q == ST_LOCKED);

    always_comb begin
        state_n  = state_q;
        match_n  = match_q;
        settle_n = settle_q;
        slips_n  = slip_cnt;
        err_n    = align_err;
        slip_req = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (align_en) begin
                    state_n = ST_HUNT;
                    slips_n = '0;
                end
            end
            ST_HUNT: begin
                if (!align_en) begin
                    state_n = ST_IDLE;
                end else if (dout_valid) begin
                    if (good) begin
                        match_n = MW'(1);
                        state_n = (MATCH_COUNT <= 1) ? ST_LOCKED : ST_CHECK;
                    end else begin
                        slip_req = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!align_en) begin
                    state_n = ST_IDLE;
                end else if (dout_valid) begin
                    if (settle_q <= SW'(1)) state_n = ST_HUNT;
                    else                    settle_n = settle_q - SW'(1);
                end
            end
            ST_CHECK: begin
                if (!align_en) begin
                    state_n = ST_IDLE;
                end else if (dout_valid) begin
                    if (good) begin
                        if (32'(match_q) + 1 >= MATCH_COUNT) state_n = ST_LOCKED;
                        else                                 match_n = match_q + MW'(1);
                    end else begin
                        slip_req = 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (align_en && dout_valid && !good) begin
                    state_n = ST_HUNT;
                    slips_n = '0;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Slips are only issued from HUNT/CHECK, i.e. while not locked.
        if (slip_req) begin
            state_n  = ST_WAIT;
            settle_n = SW'(SETTLE);
            if (slip_cnt != 4'hf) slips_n = slip_cnt + 4'd1;
            if (32'(slips_n) >= MAX_SLIPS) err_n = 1'b1;
        end
    end

    always_ff @(posedge clk320 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            match_q   <= '0;
            settle_q  <= '0;
            slip_cnt  <= '0;
            align_err <= 1'b0;
        end else begin
            state_q   <= state_n;
            match_q   <= match_n;
            settle_q  <= settle_n;
            slip_cnt  <= slips_n;
            align_err <= err_n;
        end
    end

endmodule

// File: tb/tb_adc_if_2to5.sv
// Scoreboard bench for adc_if_2to5: a sample-queue reference model predicts
// every output word plus the aligner flags after it; a negedge monitor compares.
module tb_adc_if_2to5;
    import adc_if_pkg::*;

    localparam sample_t TB_BASE = 14'h0100;
    localparam int MATCH = 16;
    localparam int SETTLE = 4;
    localparam int MAXS = 10;

    localparam int M_IDLE = 0, M_HUNT = 1, M_WAIT = 2, M_CHECK = 3, M_LOCKED = 4;

    logic       clk320 = 1'b0;
    logic       reset_n = 1'b0;
    logic       din_valid = 1'b0;
    beat_t      din = '0;
    logic       align_en = 1'b0;
    logic       dout_valid;
    word_t      dout;
    logic       locked;
    logic       align_err;
    logic [3:0] slip_cnt;

    adc_if_2to5 dut (
        .clk320     (clk320),
        .reset_n    (reset_n),
        .din_valid  (din_valid),
        .din        (din),
        .align_en   (align_en),
        .dout_valid (dout_valid),
        .dout       (dout),
        .locked     (locked),
        .align_err  (align_err),
        .slip_cnt   (slip_cnt)
    );

    always #5 clk320 = ~clk320;

    typedef struct {
        word_t      w;
        logic       lk;
        logic [3:0] sc;
        logic       er;
    } exp_t;

    exp_t    sbq[$];
    exp_t    last_e;
    bit      chk_st = 1'b0;
    int      n_cmp = 0;
    int      n_bad = 0;

    // reference model state
    sample_t mq[$];
    int      m_st, m_match, m_settle, m_slips;
    bit      m_err, m_pend;

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit train_ok(word_t w);
        for (int k = 0; k < 5; k++)
            if (int'(w[k]) != (int'(TB_BASE) + k) % (1 << W)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic sample_t tr(int i);
        return sample_t'(int'(TB_BASE) + (i + 2) % 5);
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_match = 0; m_settle = 0; m_slips = 0;
        m_err = 1'b0; m_pend = 1'b0;
        mq.delete();
        sbq.delete();
    endtask

    task automatic model_slip();
        m_pend = 1'b1;
        if (m_slips < 15) m_slips++;
        if (m_slips >= MAXS) m_err = 1'b1;
        m_st = M_WAIT;
        m_settle = 0;
    endtask

    task automatic model_word(word_t w);
        bit ok;
        exp_t e;
        ok = train_ok(w);
        case (m_st)
            M_HUNT:   if (ok) begin m_match = 1; m_st = M_CHECK; end else model_slip();
            M_WAIT:   begin m_settle++; if (m_settle == SETTLE) m_st = M_HUNT; end
            M_CHECK:  if (ok) begin m_match++; if (m_match == MATCH) m_st = M_LOCKED; end
                      else model_slip();
            M_LOCKED: if (align_en && !ok) begin m_st = M_HUNT; m_slips = 0; end
            default: ;
        endcase
        e.w = w; e.lk = (m_st == M_LOCKED); e.sc = 4'(m_slips); e.er = m_err;
        sbq.push_back(e);
    endtask

    task automatic model_beat(sample_t a, sample_t b);
        word_t w;
        if (m_pend) m_pend = 1'b0;
        else        mq.push_back(a);
        mq.push_back(b);
        while (mq.size() >= 5) begin
            for (int k = 0; k < 5; k++) w[k] = mq.pop_front();
            model_word(w);
        end
    endtask

    // Called at a negedge; returns at a later negedge.
    task automatic send_beat(sample_t a, sample_t b, int gap);
        din[0] = a; din[1] = b; din_valid = 1'b1;
        model_beat(a, b);
        @(negedge clk320);
        din_valid = 1'b0;
        repeat (gap) @(negedge clk320);
    endtask

    task automatic idle(int n);
        din_valid = 1'b0;
        repeat (n) @(negedge clk320);
    endtask

    task automatic set_align(bit v);
        align_en = v;
        if (v && m_st == M_IDLE) begin m_st = M_HUNT; m_slips = 0; end
        if (!v && (m_st == M_HUNT || m_st == M_WAIT || m_st == M_CHECK)) m_st = M_IDLE;
        repeat (2) @(negedge clk320);
    endtask

    // monitor: word on the dout_valid cycle, flags one cycle later
    always @(negedge clk320) begin
        if (chk_st) begin
            chk("flag_locked", int'(locked), int'(last_e.lk));
            chk("flag_slip_cnt", int'(slip_cnt), int'(last_e.sc));
            chk("flag_align_err", int'(align_err), int'(last_e.er));
            chk_st = 1'b0;
        end
        if (reset_n && dout_valid) begin
            n_cmp++;
            if (sbq.size() == 0) begin
                n_bad++;
                $display("FAIL spurious_word: got dout=%h, expected no word", dout);
            end else begin
                last_e = sbq.pop_front();
                if (dout !== last_e.w) begin
                    n_bad++;
                    $display("FAIL word: got %h, expected %h", dout, last_e.w);
                end
                chk_st = 1'b1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        model_reset();
        repeat (3) @(negedge clk320);
        chk("rst_dout_nonzero", int'(dout != '0), 0);
        chk("rst_dout_valid", int'(dout_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_align_err", int'(align_err), 0);
        chk("rst_slip_cnt", int'(slip_cnt), 0);
        reset_n = 1'b1;
        @(negedge clk320);

        // plain ramp, back-to-back, aligner off
        send_beat(0, 1, 0);
        send_beat(2, 3, 0);
        send_beat(4, 5, 0);
        chk("lat_beat3", int'(dout_valid), 1);
        send_beat(6, 7, 0);
        chk("pulse_single", int'(dout_valid), 0);
        send_beat(8, 9, 0);
        chk("lat_beat5", int'(dout_valid), 1);
        idle(4);
        chk("t1_locked", int'(locked), 0);

        // ramp with random gaps
        for (int i = 0; i < 40; i++)
            send_beat(sample_t'(10 + 2 * i), sample_t'(11 + 2 * i), int'($urandom_range(0, 3)));
        idle(4);

        // training ramp offset by two samples
        set_align(1'b1);
        for (int i = 0; i < 150; i++) send_beat(tr(2 * i), tr(2 * i + 1), 1);
        idle(4);
        chk("t3_slip_cnt", int'(slip_cnt), 3);
        chk("t3_locked", int'(locked), 1);

        // locked with aligner off ignores content
        set_align(1'b0);
        for (int i = 0; i < 30; i++)
            send_beat(sample_t'($urandom), sample_t'($urandom), int'($urandom_range(0, 2)));
        idle(4);
        chk("t4_hold_locked", int'(locked), 1);
        set_align(1'b1);
        for (int i = 0; i < 3; i++) send_beat(sample_t'($urandom), sample_t'($urandom), 1);
        idle(3);
        chk("t4_unlocked", int'(locked), 0);
        for (int i = 0; i < 10; i++) send_beat(sample_t'($urandom), sample_t'($urandom), 1);
        idle(4);

        // constant zero input never locks
        set_align(1'b0);
        set_align(1'b1);
        for (int i = 0; i < 260; i++) send_beat('0, '0, 1);
        idle(4);
        chk("t5_align_err", int'(align_err), 1);
        chk("t5_slip_cnt", int'(slip_cnt), 15);
        chk("t5_locked", int'(locked), 0);

        // reset mid-word with occupancy 3
        set_align(1'b0);
        g = 0;
        while (mq.size() != 3 && g < 10) begin
            send_beat(sample_t'(g), sample_t'(g + 1), 0);
            g++;
        end
        idle(3);
        chk("t6_occupancy", mq.size(), 3);
        chk("t6_drained", sbq.size(), 0);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_dout_nonzero", int'(dout != '0), 0);
        chk("t6_dout_valid", int'(dout_valid), 0);
        chk("t6_locked", int'(locked), 0);
        chk("t6_align_err", int'(align_err), 0);
        chk("t6_slip_cnt", int'(slip_cnt), 0);
        model_reset();
        @(negedge clk320);
        reset_n = 1'b1;
        @(negedge clk320);
        for (int i = 0; i < 5; i++)
            send_beat(sample_t'(100 + 2 * i), sample_t'(101 + 2 * i), 0);
        idle(4);

        chk("sb_empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_if_2to5.md
# adc_if_2to5

Receive-side 2-to-5 sample gearbox with training-pattern word aligner. It consumes 2-sample beats deserialized from a 2-lane DDR sample link and rebuilds 5-sample parallel words at 320 MHz. It is the inverse of the DAC-side 5-to-2 path and sits between the input deserializers and the capture FIFO. An aligner FSM slips the sample phase against a known ramp until word boundaries lock.

## Interface
- W, 14, sample width
- TRAIN_BASE, 14'h0100, expected value of sample 0 in a training word
- MATCH_COUNT, 16, consecutive good training words required for lock
- SETTLE, 4, output words ignored after each slip
- MAX_SLIPS, 10, slips without lock before align_err

Ports:
- clk320  in  1  sole clock, 320 MHz sample-word clock
- reset_n  in  1  asynchronous, active-low reset
- din_valid  in  1  din carries a new beat this cycle
- din  in  [1:0][W-1:0]  din[0] older sample, din[1] newer
- align_en  in  1  link is sending training ramp; run aligner
- dout_valid  out  1  dout holds a new 5-sample word
- dout  out  [4:0][W-1:0]  dout[0] oldest sample
- locked  out  1  word alignment achieved
- align_err  out  1  sticky; MAX_SLIPS reached without lock
- slip_cnt  out  4  slips issued since last HUNT entry

## Operation
- Gearbox: sample buffer of 6 entries plus occupancy count (0..4 between beats).
  - Each valid beat appends din[0] then din[1].
  - If occupancy is 5 or more after the append, the 5 oldest samples emit as dout, dout_valid pulses, and occupancy drops by 5.
- Slip: an internal slip request discards din[0] of the next valid beat, so only din[1] is appended.
  - A slip requested with no din_valid stays pending until the next valid beat.
  - Only one slip is ever pending; a second request while one is pending is dropped.
- Training word is good when dout[k] == TRAIN_BASE + k for k=0..4, with modulo-2^W addition.
- Aligner FSM, states IDLE, HUNT, WAIT, CHECK, LOCKED:
  - IDLE: locked=0. align_en=1 -> HUNT with slip_cnt cleared.
  - HUNT: on dout_valid, a good word -> CHECK with match counter =1. A bad word issues a slip, increments slip_cnt, and goes to WAIT.
  - WAIT: counts SETTLE dout_valid pulses, then returns to HUNT.
  - CHECK: each good word increments the match counter; reaching MATCH_COUNT -> LOCKED. A bad word issues a slip -> WAIT.
  - LOCKED: locked=1. A bad word while align_en=1 -> HUNT with slip_cnt cleared, locked=0. With align_en=0, stays LOCKED and ignores data content.
  - align_en=0 in HUNT, WAIT or CHECK -> IDLE.
- align_err sets when slip_cnt reaches MAX_SLIPS while not locked. HUNT keeps running, and slip_cnt saturates at 15. align_err clears only on reset.

## Timing
- Reset values: dout=0, dout_valid=0, locked=0, align_err=0, slip_cnt=0. Occupancy is 0, no slip is pending, FSM is in IDLE.
- Latency: dout_valid asserts 1 cycle after the clock edge that samples the completing beat. It is a single-cycle pulse, at most one per beat.
- Back-to-back beats are accepted every cycle with no stall, so no backpressure port exists.
- The aligner judges a word in the cycle dout_valid is high. The resulting slip applies to the first valid beat after that cycle.
- Reset asserted mid-word discards any partial buffer contents.

## Structure
- Package adc_if_pkg holds:
  - sample_t (logic [W-1:0]) and the beat/word array types
  - aligner state enum
  - default TRAIN_BASE
- Sub-module adc_gearbox_2to5 contains the buffer, occupancy, slip handling, dout and dout_valid. The top holds the aligner FSM, counters and flags.

## Test plan
- Ramp 0,1,2,... as beats (0,1),(2,3),(4,5),(6,7),(8,9) with align_en=0 -> words {0..4} one cycle after beat 3 and {5..9} one cycle after beat 5; locked stays 0.
- Same ramp with din_valid gaps of 0-3 cycles -> identical words in order, with no duplicate or missing dout_valid.
- align_en=1, training ramp from TRAIN_BASE offset by 2 samples -> 3 slips, lock after the next 16 good words; slip_cnt=3, locked=1.
- Locked, align_en=0, random data -> locked stays 1. Then align_en=1 with one bad word -> locked drops the next cycle and the FSM re-hunts.
- align_en=1 with constant 0 input -> align_err sets at the 10th slip, slip_cnt saturates at 15, and the FSM never reaches lock.
- Assert reset_n mid-word with occupancy 3 -> all outputs 0 immediately. After release, the next word consists only of post-reset samples.
